plot_framebuffer: RTL and testbench
===================================

// Module: plot_framebuffer
// PURPOSE
//  Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the clear and circle
//  drawers. Buffers plot requests in a small FIFO and writes them into an internal 160x120x3
//  framebuffer RAM. Provides a hardware clear sweep and an independent pipelined readback port
//  for scan-out and self-check logic.
// PARAMETERS
//  WIDTH       160  pixels per row; legal x is 0..WIDTH-1
//  HEIGHT      120  rows; legal y is 0..HEIGHT-1
//  FIFO_DEPTH  4    plot FIFO entries; must be a power of 2 and at least 2
// PORTS
//  CLOCK_50      in   1   system clock; all logic on posedge
//  Reset         in   1   synchronous, active-high reset
//  x             in   8   plot column
//  y             in   7   plot row
//  colour        in   3   plot colour
//  plot          in   1   plot request; accepted in a cycle where plot & plot_ready
//  plot_ready    out  1   FIFO not full and FSM in IDLE
//  clear_req     in   1   start a clear sweep; sampled in IDLE only
//  clear_colour  in   3   fill colour; latched when clear_req is taken
//  busy          out  1   high in DRAIN or CLEAR
//  rd_req        in   1   readback request
//  rd_x          in   8   readback column
//  rd_y          in   7   readback row
//  rd_valid      out  1   rd_colour/rd_oob valid; exactly 2 cycles after rd_req
//  rd_colour     out  3   pixel read; 0 when rd_oob
//  rd_oob        out  1   readback coordinate out of range
//  oob_count     out  8   accepted plots with x>=WIDTH or y>=HEIGHT; saturates at 255
//  drop_count    out  8   cycles with plot=1 & plot_ready=0; saturates at 255
// BEHAVIOUR
//  - Reset: FIFO empty, FSM IDLE, plot_ready=1, busy=0, rd_valid=0, rd_colour=0, rd_oob=0,
//    oob_count=0, drop_count=0. RAM contents are not reset.
//  - Address is y*WIDTH+x, 15 bits. For WIDTH=160 it is formed as (y<<7)+(y<<5)+x; no multiplier.
//  - Accepted plot: if out of range, discard it and increment oob_count; never enqueue it.
//    Otherwise push {addr, colour}.
//  - FIFO pops one entry per cycle when non-empty and the FSM is not in CLEAR.
//    The RAM write occurs in the pop cycle.
//  - Push and pop in the same cycle is legal; occupancy is unchanged.
//  - plot_ready is combinational from the registered full flag and the state. When the FIFO is
//    full, plot_ready=0 and the plot is counted in drop_count, not stored.
//  - FSM IDLE: on clear_req, latch clear_colour and go to DRAIN.
//    clear_req outside IDLE is ignored.
//  - FSM DRAIN: plot_ready=0; pop the FIFO until empty, then go to CLEAR with addr=0.
//  - FSM CLEAR: write clear_colour to addr, addr++. After addr=WIDTH*HEIGHT-1 is written, go to
//    IDLE. A full clear takes 19200 cycles, plus the DRAIN cycles.
//  - Readback: rd_req is independent of the FSM and serviced every cycle, pipelined.
//    Stage 1 registers the address and the oob flag. Stage 2 registers RAM data and rd_valid.
//  - Read and write to the same address in the same cycle return the OLD value (read-before-write).
//  - rd_colour holds its last value when rd_valid=0.
//  - Counters saturate: at 255 they stay 255.
//  - Reset mid-operation: Reset asserted in any state returns to IDLE in the next cycle.
//    FIFO contents are lost. A partial clear leaves the RAM partially written, which is legal.
// TESTING
//  1. Reset, plot (10,20,c=5) for 1 cycle, wait 3, rd_req (10,20) -> rd_valid 2 cycles later,
//     rd_colour=5, rd_oob=0.
//  2. Plot (160,0) then (0,120) -> oob_count=2, RAM unchanged; rd_req (200,5) -> rd_oob=1,
//     rd_colour=0.
//  3. Stall pop path (hold in DRAIN-free burst): 6 back-to-back plots with FIFO_DEPTH=4 ->
//     writes complete and FIFO never overflows; force full via clear_req mid-burst ->
//     drop_count equals rejected cycles.
//  4. clear_req with clear_colour=3 and 2 entries queued -> queued pixels written first, then
//     busy high for exactly 19200 CLEAR cycles. Afterwards (0,0), (159,119) and (79,59) read 3.
//  5. Same-cycle write and read of (5,5), old=1, new=6 -> read returns 1; a read 1 cycle later
//     returns 6.
//  6. Reset at addr ~9000 of CLEAR -> next cycle busy=0, plot_ready=1, counters 0; a new clear
//     then completes normally.

Source files
------------

// File: rtl/plot_fb_if.sv
// Pixel-plot, clear-control and readback signals between the drawers and the framebuffer.
interface plot_fb_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       plot_ready;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       busy;
  logic       rd_req;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_valid;
  logic [2:0] rd_colour;
  logic       rd_oob;
  logic [7:0] oob_count;
  logic [7:0] drop_count;

  modport master (
    output x, y, colour, plot, clear_req, clear_colour, rd_req, rd_x, rd_y,
    input  plot_ready, busy, rd_valid, rd_colour, rd_oob, oob_count, drop_count
  );

  modport slave (
    input  x, y, colour, plot, clear_req, clear_colour, rd_req, rd_x, rd_y,
    output plot_ready, busy, rd_valid, rd_colour, rd_oob, oob_count, drop_count
  );
endinterface

// File: rtl/plot_framebuffer.sv
// 160x120x3 framebuffer fed through a small plot FIFO, with a hardware clear sweep
// and a two-stage pipelined readback port that is independent of the write side.
module plot_framebuffer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      CLOCK_50,
  input  logic      Reset,
  plot_fb_if.slave  bus
);
  localparam int          NPIX      = WIDTH * HEIGHT;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // y*160 built from two shifts so no multiplier is inferred.
  function automatic logic [14:0] pix_addr(input logic [6:0] py, input logic [7:0] px);
    logic [14:0] yy;
    yy = {8'd0, py};
    return (yy << 7) + (yy << 5) + {7'd0, px};
  endfunction

  function automatic logic out_of_range(input logic [6:0] py, input logic [7:0] px);
    return ({24'd0, px} >= 32'(WIDTH)) || ({25'd0, py} >= 32'(HEIGHT));
  endfunction

  state_t          state_q, state_d;
  logic [17:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [PW:0]     count_q, count_d;
  logic            full_q;
  logic [14:0]     clr_addr_q, clr_addr_d;
  logic [2:0]      clr_colour_q;
  logic [7:0]      oob_cnt_q, drop_cnt_q;
  logic            rd_v1_q, rd_oob1_q;
  logic [14:0]     rd_addr1_q;
  logic            rd_valid_q, rd_oob_q;
  logic [2:0]      rd_colour_q;
  logic [2:0]      mem_q [NPIX];

  logic            plot_ready_s, accept_s, in_oob_s, push_s, pop_s;
  logic            wr_en_s;
  logic [14:0]     wr_addr_s;
  logic [2:0]      wr_data_s;

  assign plot_ready_s = !full_q && (state_q == IDLE);
  assign accept_s     = bus.plot && plot_ready_s;
  assign in_oob_s     = out_of_range(bus.y, bus.x);
  assign push_s       = accept_s && !in_oob_s;
  assign pop_s        = (count_q != '0) && (state_q != CLEAR);

  // Next-state logic for the IDLE/DRAIN/CLEAR controller.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) state_d = DRAIN;
        else               state_d = IDLE;
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d    = CLEAR;
          clr_addr_d = 15'd0;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + 15'd1;
        if (clr_addr_q == LAST_ADDR) state_d = IDLE;
        else                         state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM write port: FIFO pops and the clear sweep are mutually exclusive by state.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 15'd0;
    wr_data_s = 3'd0;
    if (pop_s) begin
      wr_en_s                = 1'b1;
      {wr_addr_s, wr_data_s} = fifo_q[rptr_q];
    end else if (state_q == CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_addr_q;
      wr_data_s = clr_colour_q;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Controller, FIFO pointers and saturating event counters.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      clr_addr_q   <= 15'd0;
      clr_colour_q <= 3'd0;
      oob_cnt_q    <= 8'd0;
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_CNT);
      if (push_s) wptr_q <= wptr_q + PW'(1);
      if (pop_s)  rptr_q <= rptr_q + PW'(1);
      if ((state_q == IDLE) && bus.clear_req) clr_colour_q <= bus.clear_colour;
      if (accept_s && in_oob_s && (oob_cnt_q != 8'd255)) oob_cnt_q <= oob_cnt_q + 8'd1;
      if (bus.plot && !plot_ready_s && (drop_cnt_q != 8'd255)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // FIFO storage; contents beyond the pointers are don't-care, so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (push_s) fifo_q[wptr_q] <= {pix_addr(bus.y, bus.x), bus.colour};
  end

  // Framebuffer RAM write; contents survive reset.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en_s) mem_q[wr_addr_s] <= wr_data_s;
  end

  // Readback pipeline; stage 2 reads the RAM before any same-cycle write lands.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      rd_v1_q     <= 1'b0;
      rd_oob1_q   <= 1'b0;
      rd_addr1_q  <= 15'd0;
      rd_valid_q  <= 1'b0;
      rd_oob_q    <= 1'b0;
      rd_colour_q <= 3'd0;
    end else begin
      rd_v1_q    <= bus.rd_req;
      rd_oob1_q  <= out_of_range(bus.rd_y, bus.rd_x);
      rd_addr1_q <= pix_addr(bus.rd_y, bus.rd_x);
      rd_valid_q <= rd_v1_q;
      if (rd_v1_q) begin
        rd_oob_q    <= rd_oob1_q;
        rd_colour_q <= rd_oob1_q ? 3'd0 : mem_q[rd_addr1_q];
      end
    end
  end

  assign bus.plot_ready = plot_ready_s;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_colour  = rd_colour_q;
  assign bus.rd_oob     = rd_oob_q;
  assign bus.oob_count  = oob_cnt_q;
  assign bus.drop_count = drop_cnt_q;
endmodule

// File: tb/tb_plot_framebuffer.sv
// Bench for plot_framebuffer: directed scenarios plus random traffic, checked every cycle
// against a queue/array model of the framebuffer behaviour.
module tb_plot_framebuffer;
  localparam int W = 160, H = 120, D = 4, NPIX = W * H;

  logic clk = 1'b0;
  logic rst;
  plot_fb_if bus ();

  plot_framebuffer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .CLOCK_50(clk),
    .Reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // model state: pixel array (-1 = never written), pending plot queue, mode 0/1/2 = idle/drain/clear
  int fb [NPIX];
  int q_addr[$], q_col[$];
  int mode = 0, clr_pos = 0, clr_col = 0, m_oob = 0, m_drop = 0;
  int s1_valid = 0, s1_oob = 0, s1_addr = 0;
  int m_valid = 0, m_col = 0, m_oobf = 0;
  int s_ready, s_busy, s_valid, s_col, s_oob, s_oobc, s_dropc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    s_ready = int'(bus.plot_ready); s_busy = int'(bus.busy); s_valid = int'(bus.rd_valid);
    s_col = int'(bus.rd_colour); s_oob = int'(bus.rd_oob);
    s_oobc = int'(bus.oob_count); s_dropc = int'(bus.drop_count);
    chk("plot_ready", s_ready, (q_addr.size() < D && mode == 0) ? 1 : 0);
    chk("busy", s_busy, (mode != 0) ? 1 : 0);
    chk("rd_valid", s_valid, m_valid);
    chk("rd_oob", s_oob, m_oobf);
    chk("oob_count", s_oobc, m_oob);
    chk("drop_count", s_dropc, m_drop);
    if (m_col >= 0) chk("rd_colour", s_col, m_col);
  endtask

  task automatic model_step();
    int ready, was_empty, px, py;
    if (rst) begin
      q_addr.delete(); q_col.delete();
      mode = 0; m_oob = 0; m_drop = 0; s1_valid = 0; m_valid = 0; m_col = 0; m_oobf = 0;
      return;
    end
    ready = (q_addr.size() < D && mode == 0) ? 1 : 0;
    m_valid = s1_valid;
    if (s1_valid != 0) begin
      m_oobf = s1_oob;
      m_col  = (s1_oob != 0) ? 0 : fb[s1_addr];
    end
    s1_valid = int'(bus.rd_req);
    px = int'(bus.rd_x); py = int'(bus.rd_y);
    s1_oob  = (px >= W || py >= H) ? 1 : 0;
    s1_addr = (s1_oob != 0) ? 0 : py * W + px;
    if (bus.plot && ready == 0 && m_drop < 255) m_drop++;
    was_empty = (q_addr.size() == 0) ? 1 : 0;
    if (was_empty == 0 && mode != 2) fb[q_addr.pop_front()] = q_col.pop_front();
    case (mode)
      0: if (bus.clear_req) begin clr_col = int'(bus.clear_colour); mode = 1; end
      1: if (was_empty != 0) begin mode = 2; clr_pos = 0; end
      default: begin
        fb[clr_pos] = clr_col;
        if (clr_pos == NPIX - 1) mode = 0; else clr_pos++;
      end
    endcase
    if (bus.plot && ready != 0) begin
      px = int'(bus.x); py = int'(bus.y);
      if (px >= W || py >= H) begin
        if (m_oob < 255) m_oob++;
      end else begin
        q_addr.push_back(py * W + px);
        q_col.push_back(int'(bus.colour));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic plot1(input int px, input int py, input int c);
    bus.plot = 1'b1; bus.x = 8'(px); bus.y = 7'(py); bus.colour = 3'(c);
    tick();
    bus.plot = 1'b0;
  endtask

  task automatic read_lit(input string name, input int px, input int py, input int ecol, input int eoob);
    bus.rd_req = 1'b1; bus.rd_x = 8'(px); bus.rd_y = 7'(py);
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();
    chk({name, "_valid"}, s_valid, 1);
    chk({name, "_colour"}, s_col, ecol);
    chk({name, "_oob"}, s_oob, eoob);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int n = 0; n < 25000; n++) begin
      tick();
      if (s_busy != 0) cnt++;
      else break;
    end
    chk("clear_finished", s_busy, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < NPIX; i++) fb[i] = -1;
    rst = 1'b1;
    bus.plot = 1'b0; bus.x = 8'd0; bus.y = 7'd0; bus.colour = 3'd0;
    bus.clear_req = 1'b0; bus.clear_colour = 3'd0;
    bus.rd_req = 1'b0; bus.rd_x = 8'd0; bus.rd_y = 7'd0;
    tick(); tick();
    chk("reset_ready", s_ready, 1);
    chk("reset_rd_colour", s_col, 0);
    rst = 1'b0;

    // single plot then readback
    plot1(10, 20, 5);
    tick(); tick(); tick();
    chk("model_pix_10_20", fb[20 * W + 10], 5);
    read_lit("t1", 10, 20, 5, 0);

    // out-of-range plots and readback
    plot1(160, 0, 7);
    plot1(0, 120, 7);
    tick();
    chk("t2_oob_count", s_oobc, 2);
    read_lit("t2_oobread", 200, 5, 0, 1);
    read_lit("t2_unchanged", 10, 20, 5, 0);

    // read-before-write on (5,5)
    plot1(5, 5, 1);
    tick(); tick();
    bus.plot = 1'b1; bus.x = 8'd5; bus.y = 7'd5; bus.colour = 3'd6;
    bus.rd_req = 1'b1; bus.rd_x = 8'd5; bus.rd_y = 7'd5;
    tick();
    bus.plot = 1'b0;
    tick();
    bus.rd_req = 1'b0;
    tick();
    chk("t5_old", s_col, 1);
    tick();
    chk("t5_new", s_col, 6);

    // six back-to-back plots, then a burst with a clear taken mid-way
    for (int i = 0; i < 6; i++) begin
      bus.plot = 1'b1; bus.x = 8'(30 + i); bus.y = 7'(40); bus.colour = 3'(i + 1);
      tick();
    end
    bus.plot = 1'b0;
    tick(); tick();
    chk("t3_no_drop", s_dropc, 0);
    read_lit("t3_first", 30, 40, 1, 0);
    read_lit("t3_last", 35, 40, 6, 0);
    bus.clear_colour = 3'd0;
    for (int i = 0; i < 6; i++) begin
      bus.plot = 1'b1; bus.x = 8'(50 + i); bus.y = 7'(60); bus.colour = 3'd2;
      bus.clear_req = (i == 2) ? 1'b1 : 1'b0;
      tick();
    end
    bus.plot = 1'b0; bus.clear_req = 1'b0;
    wait_idle(cnt);
    chk("t3_drop", s_dropc, 3);
    read_lit("t3_cleared", 52, 60, 0, 0);

    // clear with two queued plots; plot held during the sweep to saturate drops
    bus.clear_colour = 3'd3;
    plot1(7, 8, 4);
    bus.plot = 1'b1; bus.x = 8'd9; bus.y = 7'd8; bus.colour = 3'd4; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0; bus.x = 8'd1; bus.y = 7'd1; bus.colour = 3'd3;
    wait_idle(cnt);
    bus.plot = 1'b0;
    chk("t4_busy_cycles", cnt, 19202);
    chk("t4_drop_sat", s_dropc, 255);
    tick(); tick();
    read_lit("t4_0_0", 0, 0, 3, 0);
    read_lit("t4_159_119", 159, 119, 3, 0);
    read_lit("t4_79_59", 79, 59, 3, 0);
    read_lit("t4_queued", 9, 8, 3, 0);

    // oob counter saturation
    for (int i = 0; i < 260; i++) plot1(200, i % 128, 1);
    tick();
    chk("oob_sat", s_oobc, 255);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.plot = 1'($urandom_range(0, 1));
      bus.x = 8'($urandom_range(0, 170)); bus.y = 7'($urandom_range(0, 125));
      bus.colour = 3'($urandom_range(0, 7));
      bus.rd_req = 1'($urandom_range(0, 1));
      bus.rd_x = 8'($urandom_range(0, 165)); bus.rd_y = 7'($urandom_range(0, 123));
      tick();
    end
    bus.plot = 1'b0; bus.rd_req = 1'b0;
    tick(); tick();

    // reset in the middle of a clear sweep
    bus.clear_colour = 3'd5; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 9000; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_busy", s_busy, 0);
    chk("t6_ready", s_ready, 1);
    chk("t6_oob", s_oobc, 0);
    chk("t6_drop", s_dropc, 0);
    bus.clear_colour = 3'd6; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    wait_idle(cnt);
    chk("t6_busy_cycles", cnt, 19201);
    read_lit("t6_79_59", 79, 59, 6, 0);
    read_lit("t6_159_119", 159, 119, 6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
